// File: rtl/fpu_pkg.sv
// Shared definitions for the FP result writeback path: alu_op codes,
// writeback entry layout and the op classification helpers.
package fpu_pkg;

    // alu_op codes driven by the FP result mux
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_SQRT = 5'b00101;
    localparam logic [4:0] OP_MIN  = 5'b00110;
    localparam logic [4:0] OP_MAX  = 5'b00111;
    localparam logic [4:0] OP_LT   = 5'b01000;
    localparam logic [4:0] OP_EQ   = 5'b01001;
    localparam logic [4:0] OP_LE   = 5'b01010;
    localparam logic [4:0] OP_CONV = 5'b01110;

    // One queued writeback: result word, destination index, target file
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_int;
    } wb_entry_t;

    // Codes the result mux can legitimately produce
    function automatic logic is_legal_op(input logic [4:0] op);
        return ((op >= OP_ADD) && (op <= OP_LE)) || (op == OP_CONV);
    endfunction

    // Comparisons always write the integer file; a conversion does so
    // only when the upstream flags it as float-to-int.
    function automatic logic is_int_dest(input logic [4:0] op, input logic conv_to_int);
        return (op == OP_LT) || (op == OP_EQ) || (op == OP_LE) ||
               ((op == OP_CONV) && conv_to_int);
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Synchronous FIFO of writeback entries. Exposes occupancy and the
// destination fields of every slot so the owner can build hazard bitmaps.
module fpu_wb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             wr_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      occ_valid,
    output logic [DEPTH-1:0][4:0] slot_rd,
    output logic [DEPTH-1:0]      slot_is_int
);

    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]            count_q,  count_d;
    wb_entry_t [DEPTH-1:0]  mem_q,    mem_d;
    logic                   do_push, do_pop;
    logic [AW-1:0]          offset;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;

    // Next-state for pointers, count and storage
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps modulo DEPTH (power of two)
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;          // idle, or push+pop together
        endcase
    end

    // Head presentation (zero when empty) and per-slot occupancy
    always_comb begin
        head        = empty ? '0 : mem_q[rd_ptr_q];
        offset      = '0;
        occ_valid   = '0;
        slot_rd     = '0;
        slot_is_int = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // A slot is live when its distance from the head is below count
            offset         = AW'(i) - rd_ptr_q;
            occ_valid[i]   = ({1'b0, offset} < count_q);
            slot_rd[i]     = mem_q[i].rd;
            slot_is_int[i] = mem_q[i].is_int;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; liveness is tracked by count/pointers, so stale words are never observed.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fpu_result_wb_queue.sv
// Writeback queue behind the FP result mux: classifies each result as an
// FP- or integer-register write, buffers it, and presents it to the
// register-file write port with pending-destination bitmaps for issue.
module fpu_result_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_out,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  in_rd,
    input  logic        conv_to_int,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_is_int,
    output logic        illegal_op,
    output logic [31:0] pending_fp,
    output logic [31:0] pending_int
);

    logic                  accept, op_legal, op_int, push, pop;
    logic                  illegal_q, illegal_d;
    wb_entry_t             wr_entry, head;
    logic [AW:0]           fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [DEPTH-1:0]      occ_valid;
    logic [DEPTH-1:0][4:0] slot_rd;
    logic [DEPTH-1:0]      slot_is_int;

    assign in_ready   = (fifo_count != (AW+1)'(DEPTH));
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = head.data;
    assign out_rd     = head.rd;
    assign out_is_int = head.is_int;
    assign illegal_op = illegal_q;

    // Classify the incoming result and decide whether it enters the queue
    always_comb begin
        accept   = in_valid && in_ready;
        op_legal = is_legal_op(alu_op);
        op_int   = is_int_dest(alu_op, conv_to_int);
        // Illegal ops and integer writes to x0 are consumed without enqueue
        push      = accept && op_legal && !(op_int && (in_rd == 5'd0)) && !fifo_full;
        illegal_d = accept && !op_legal;
        wr_entry.data   = float_out;
        wr_entry.rd     = in_rd;
        wr_entry.is_int = op_int;
    end

    // Pending-destination bitmaps: OR of every live entry's destination
    always_comb begin
        pending_fp  = '0;
        pending_int = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_valid[i]) begin
                if (slot_is_int[i]) pending_int[slot_rd[i]] = 1'b1;
                else                pending_fp[slot_rd[i]]  = 1'b1;
            end
        end
    end

    // Registered illegal-op pulse, one cycle after the offending accept
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    fpu_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .wr_entry    (wr_entry),
        .pop         (pop),
        .head        (head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .occ_valid   (occ_valid),
        .slot_rd     (slot_rd),
        .slot_is_int (slot_is_int)
    );

endmodule

// File: tb/tb_fpu_result_wb_queue.sv
// Directed bench for fpu_result_wb_queue with a scoreboard of expected
// writebacks compared whenever the DUT completes a handshake.
module tb_fpu_result_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_out;
    logic [4:0]  alu_op;
    logic [4:0]  in_rd;
    logic        conv_to_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_is_int;
    logic        illegal_op;
    logic [31:0] pending_fp;
    logic [31:0] pending_int;

    int tests_run = 0;
    int fails     = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_int;
    } exp_t;

    exp_t sb[$];

    fpu_result_wb_queue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .float_out   (float_out),
        .alu_op      (alu_op),
        .in_rd       (in_rd),
        .conv_to_int (conv_to_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_is_int  (out_is_int),
        .illegal_op  (illegal_op),
        .pending_fp  (pending_fp),
        .pending_int (pending_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] d,
                         input logic [4:0] rd, input logic conv);
        in_valid    = v;
        alu_op      = op;
        float_out   = d;
        in_rd       = rd;
        conv_to_int = conv;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic expect_wb(input logic [31:0] d, input logic [4:0] rd, input logic is_int);
        exp_t e;
        e.data   = d;
        e.rd     = rd;
        e.is_int = is_int;
        sb.push_back(e);
    endtask

    // Requires out_ready=1; bounded so a stuck queue is reported, not hung on
    task automatic wait_drain(input int budget);
        int n = 0;
        while (out_valid && (n < budget)) begin
            step();
            n++;
        end
        check("drain_timeout", out_valid, 1'b0);
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            check("pop_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data",   out_data,   e.data);
                check("out_rd",     out_rd,     e.rd);
                check("out_is_int", out_is_int, e.is_int);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
        step();
        step();
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_in_ready",    in_ready,    1'b1);
        check("rst_pending_fp",  pending_fp,  32'd0);
        check("rst_pending_int", pending_int, 32'd0);
        check("rst_out_data",    out_data,    32'd0);
        check("rst_illegal",     illegal_op,  1'b0);

        // Single FP result: one-cycle latency, pending bit for exactly one cycle
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 5'b00001, 32'h3F80_0000, 5'd3, 1'b0);
        expect_wb(32'h3F80_0000, 5'd3, 1'b0);
        #1;
        check("no_forward", out_valid, 1'b0);
        step();
        idle();
        check("t1_out_valid",  out_valid,   1'b1);
        check("t1_pending_fp", pending_fp,  32'h0000_0008);
        check("t1_pend_int",   pending_int, 32'd0);
        step();
        check("t1_pending_clr", pending_fp, 32'd0);
        check("t1_empty",       out_valid,  1'b0);

        // Classification: comparison -> int, conv(0) -> fp, conv(1) -> int
        out_ready = 1'b0;
        drive(1'b1, 5'b01000, 32'd1, 5'd5, 1'b0); expect_wb(32'd1, 5'd5, 1'b1); step();
        drive(1'b1, 5'b01110, 32'd2, 5'd5, 1'b0); expect_wb(32'd2, 5'd5, 1'b0); step();
        drive(1'b1, 5'b01110, 32'd3, 5'd7, 1'b1); expect_wb(32'd3, 5'd7, 1'b1); step();
        idle();
        check("t2_pending_int", pending_int, 32'h0000_00A0);
        check("t2_pending_fp",  pending_fp,  32'h0000_0020);
        check("t2_head_is_int", out_is_int, 1'b1);
        check("t2_head_rd",     out_rd,     5'd5);
        step();
        check("t2_head_hold",   out_data,   32'd1);
        out_ready = 1'b1;
        wait_drain(10);
        check("t2_pend_clr", {pending_int, pending_fp}, 64'd0);

        // Illegal codes: consumed, not enqueued, pulse the cycle after
        for (int i = 0; i < 6; i++) begin
            logic [4:0] bad_ops [6];
            bad_ops = '{5'b00000, 5'b01011, 5'b01100, 5'b01101, 5'b01111, 5'b11111};
            drive(1'b1, bad_ops[i], 32'hDEAD_0000 + 32'(i), 5'd4, 1'b0);
            step();
            check("illegal_pulse",    illegal_op, 1'b1);
            check("illegal_no_enq",   out_valid,  1'b0);
        end
        idle();
        step();
        check("illegal_one_cycle", illegal_op, 1'b0);

        // Integer writes to x0 are silently dropped; FP writes to f0 are kept
        drive(1'b1, 5'b01001, 32'd77, 5'd0, 1'b0); step();
        check("x0_no_illegal", illegal_op, 1'b0);
        drive(1'b1, 5'b01110, 32'd78, 5'd0, 1'b1); step();
        idle();
        check("x0_dropped",     out_valid,  1'b0);
        check("x0_no_illegal2", illegal_op, 1'b0);
        drive(1'b1, 5'b00010, 32'h55, 5'd0, 1'b0); expect_wb(32'h55, 5'd0, 1'b0); step();
        idle();
        check("f0_kept",    out_valid,  1'b1);
        check("f0_pending", pending_fp, 32'h0000_0001);
        wait_drain(10);

        // Fill to DEPTH with the consumer stalled; a 5th push is refused
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'b00001, 32'(i), 5'(10 + i), 1'b0);
            expect_wb(32'(i), 5'(10 + i), 1'b0);
            step();
        end
        check("full_in_ready", in_ready, 1'b0);
        drive(1'b1, 5'b00001, 32'd5, 5'd15, 1'b0);
        step();
        idle();
        check("full_head",    out_data,   32'd1);
        check("full_pending", pending_fp, 32'h0000_7800);
        out_ready = 1'b1;
        step();
        check("ready_back", in_ready, 1'b1);
        wait_drain(10);

        // Second fill and drain exercises pointer wrap
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'b00011, 32'h100 + 32'(i), 5'(16 + i), 1'b0);
            expect_wb(32'h100 + 32'(i), 5'(16 + i), 1'b0);
            step();
        end
        idle();
        check("wrap_full", in_ready, 1'b0);
        out_ready = 1'b1;
        wait_drain(10);
        check("wrap_ready", in_ready, 1'b1);

        // Push and pop together at count=2 leaves count at 2
        out_ready = 1'b0;
        drive(1'b1, 5'b00001, 32'hA, 5'd20, 1'b0); expect_wb(32'hA, 5'd20, 1'b0); step();
        drive(1'b1, 5'b00001, 32'hB, 5'd21, 1'b0); expect_wb(32'hB, 5'd21, 1'b0); step();
        out_ready = 1'b1;
        drive(1'b1, 5'b00001, 32'hC, 5'd22, 1'b0); expect_wb(32'hC, 5'd22, 1'b0); step();
        idle();
        check("pp_pending", pending_fp, 32'h0060_0000);
        check("pp_head",    out_data,   32'hB);
        wait_drain(10);

        // Streaming one per cycle from empty: no bubbles after the first
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'b00011, 32'h200 + 32'(i), 5'(i + 1), 1'b0);
            expect_wb(32'h200 + 32'(i), 5'(i + 1), 1'b0);
            step();
            check("stream_valid", out_valid, 1'b1);
            check("stream_head",  out_data,  32'h200 + 32'(i));
        end
        idle();
        step();
        check("stream_done", out_valid, 1'b0);

        // Reset mid-operation discards queued entries
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'b01000, 32'h300 + 32'(i), 5'(i), 1'b0);
            step();
        end
        idle();
        check("pre_rst_pending", pending_int, 32'h0000_000E);
        rst = 1'b1;
        step();
        check("mid_rst_valid",   out_valid,   1'b0);
        check("mid_rst_ready",   in_ready,    1'b1);
        check("mid_rst_pend_fp", pending_fp,  32'd0);
        check("mid_rst_pend_in", pending_int, 32'd0);
        check("mid_rst_data",    out_data,    32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_stale", out_valid, 1'b0);
        end

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
